// File: rtl/console_pkg.sv
// Shared constants and types for the MMIO UART console: register addresses,
// STATUS bit positions and the UART FSM state encoding used by both directions.
package console_pkg;

    localparam logic [15:0] ADDR_TXDATA = 16'h0020;
    localparam logic [15:0] ADDR_STATUS = 16'h0024;
    localparam logic [15:0] ADDR_RXDATA = 16'h0028;
    localparam logic [15:0] ADDR_CTRL   = 16'h002C;

    localparam int ST_RX_AVAIL = 0;
    localparam int ST_TX_FULL  = 1;
    localparam int ST_TX_EMPTY = 2;
    localparam int ST_TX_BUSY  = 3;
    localparam int ST_RX_OVR   = 4;
    localparam int ST_TX_OVF   = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    function automatic logic [31:0] pack_status(input logic tx_ovf, input logic rx_ovr,
                                                input logic tx_busy, input logic tx_empty,
                                                input logic tx_full, input logic rx_avail);
        return {26'b0, tx_ovf, rx_ovr, tx_busy, tx_empty, tx_full, rx_avail};
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead head output and extra-MSB pointers.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/mmio_uart_console.sv
// MMIO debug console: byte FIFOs behind a small register window, serialized 8N1.
// Define UART_LOOPBACK_EN to add the CTRL register that routes TX back into RX.
module mmio_uart_console
    import console_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] mmio_addr,
    input  logic        mmio_we,
    input  logic [7:0]  mmio_wdata,
    input  logic        mmio_re,
    output logic [31:0] mmio_rdata,
    output logic        uart_tx,
    input  logic        uart_rx,
    output logic        rx_avail,
    output logic        tx_full
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

    logic        tx_push, tx_pop, tx_empty, tx_bit, tx_line, tx_bit_end;
    logic [7:0]  tx_head, tx_shreg;
    logic [CNT_W-1:0] tx_cnt, rx_cnt;
    logic [2:0]  tx_idx, rx_idx;
    uart_state_t tx_state, tx_state_nxt, rx_state, rx_state_nxt;

    logic        rx_push, rx_pop, rx_empty, rx_full, rx_in, rx_fall, rx_bit_end, rx_start_smp;
    logic        rx_sync_p0, rx_sync_p1, rx_prev_p2, rx_ferr;
    logic [7:0]  rx_head, rx_shreg;

    logic        wr_status, tx_ovf, rx_ovr;
    logic [31:0] rd_val;

    assign tx_push   = mmio_we && (mmio_addr == ADDR_TXDATA);
    assign wr_status = mmio_we && (mmio_addr == ADDR_STATUS);
    assign rx_pop    = mmio_re && !mmio_we && (mmio_addr == ADDR_RXDATA) && !rx_empty;
    assign rx_avail  = !rx_empty;

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(clk), .reset(reset), .push(tx_push), .pop(tx_pop), .wdata(mmio_wdata),
        .rdata(tx_head), .full(tx_full), .empty(tx_empty)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(clk), .reset(reset), .push(rx_push), .pop(rx_pop), .wdata(rx_shreg),
        .rdata(rx_head), .full(rx_full), .empty(rx_empty)
    );

`ifdef UART_LOOPBACK_EN
    logic loopback;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                                      loopback <= 1'b0;
        else if (mmio_we && (mmio_addr == ADDR_CTRL))   loopback <= mmio_wdata[0];
    end

    assign uart_tx = loopback ? 1'b1 : tx_line;
    assign rx_in   = loopback ? tx_line : uart_rx;
`else
    assign uart_tx = tx_line;
    assign rx_in   = uart_rx;
`endif

    // ---- TX: serial bit is registered one cycle behind the FSM state
    assign tx_bit_end = (tx_cnt == CNT_LAST);

    always_comb begin
        tx_state_nxt = tx_state;
        tx_pop       = 1'b0;
        tx_bit       = 1'b1;
        case (tx_state)
            IDLE: if (!tx_empty) begin
                tx_pop       = 1'b1;
                tx_state_nxt = START;
            end
            START: begin
                tx_bit = 1'b0;
                if (tx_bit_end) tx_state_nxt = DATA;
            end
            DATA: begin
                tx_bit = tx_shreg[0];
                if (tx_bit_end && (tx_idx == 3'd7)) tx_state_nxt = STOP;
            end
            STOP: if (tx_bit_end) begin
                tx_pop       = !tx_empty;
                tx_state_nxt = tx_empty ? IDLE : START;
            end
            default: tx_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_state <= IDLE;
            tx_cnt   <= '0;
            tx_idx   <= '0;
            tx_line  <= 1'b1;
        end else begin
            tx_state <= tx_state_nxt;
            tx_line  <= tx_bit;
            tx_cnt   <= (tx_state == IDLE || tx_bit_end) ? '0 : tx_cnt + CNT_W'(1);
            if (tx_state != DATA)  tx_idx <= '0;
            else if (tx_bit_end)   tx_idx <= tx_idx + 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (tx_pop)                                tx_shreg <= tx_head;
        else if (tx_state == DATA && tx_bit_end)   tx_shreg <= tx_shreg >> 1;
    end

    // ---- RX: 2-flop synchronizer plus one history flop for edge detect
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_sync_p0 <= 1'b1;
            rx_sync_p1 <= 1'b1;
            rx_prev_p2 <= 1'b1;
        end else begin
            rx_sync_p0 <= rx_in;
            rx_sync_p1 <= rx_sync_p0;
            rx_prev_p2 <= rx_sync_p1;
        end
    end

    assign rx_fall      = rx_prev_p2 && !rx_sync_p1;
    assign rx_bit_end   = (rx_cnt == CNT_LAST);
    assign rx_start_smp = (rx_state == START) && (rx_cnt == CNT_HALF);

    always_comb begin
        rx_state_nxt = rx_state;
        rx_push      = 1'b0;
        case (rx_state)
            IDLE:  if (rx_fall) rx_state_nxt = START;
            START: if (rx_start_smp) rx_state_nxt = rx_sync_p1 ? IDLE : DATA;
            DATA:  if (rx_bit_end && (rx_idx == 3'd7)) rx_state_nxt = STOP;
            STOP: begin
                // After a framing error, hold here until the line returns high
                if (rx_ferr) begin
                    if (rx_sync_p1) rx_state_nxt = IDLE;
                end else if (rx_bit_end && rx_sync_p1) begin
                    rx_push      = 1'b1;
                    rx_state_nxt = IDLE;
                end
            end
            default: rx_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_state <= IDLE;
            rx_cnt   <= '0;
            rx_idx   <= '0;
            rx_ferr  <= 1'b0;
        end else begin
            rx_state <= rx_state_nxt;
            rx_cnt   <= (rx_state == IDLE || rx_bit_end || rx_start_smp) ? '0 : rx_cnt + CNT_W'(1);
            if (rx_state != DATA)  rx_idx <= '0;
            else if (rx_bit_end)   rx_idx <= rx_idx + 3'd1;
            if (rx_state != STOP)                    rx_ferr <= 1'b0;
            else if (rx_bit_end && !rx_sync_p1)      rx_ferr <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rx_state == DATA && rx_bit_end) rx_shreg <= {rx_sync_p1, rx_shreg[7:1]};
    end

    // ---- MMIO register file: sticky flags and registered load data
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_ovf <= 1'b0;
            rx_ovr <= 1'b0;
        end else begin
            tx_ovf <= (tx_push && tx_full && !tx_pop) ||
                      (tx_ovf && !(wr_status && mmio_wdata[ST_TX_OVF]));
            rx_ovr <= (rx_push && rx_full && !rx_pop) ||
                      (rx_ovr && !(wr_status && mmio_wdata[ST_RX_OVR]));
        end
    end

    always_comb begin
        rd_val = '0;
        case (mmio_addr)
            ADDR_STATUS: rd_val = pack_status(tx_ovf, rx_ovr, tx_state != IDLE,
                                              tx_empty, tx_full, rx_avail);
            ADDR_RXDATA: rd_val = {24'b0, (rx_empty ? 8'h00 : rx_head)};
`ifdef UART_LOOPBACK_EN
            ADDR_CTRL:   rd_val = {31'b0, loopback};
`endif
            default:     rd_val = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)         mmio_rdata <= '0;
        else if (mmio_we)  mmio_rdata <= '0;
        else if (mmio_re)  mmio_rdata <= rd_val;
    end

endmodule

// File: tb/tb_mmio_uart_console.sv
// Bench for mmio_uart_console at CLKS_PER_BIT=4, FIFO_DEPTH=16: register table,
// TX framing, RX host frames, overflow, glitch/framing error, reset and loopback.
module tb_mmio_uart_console;

    localparam int CPB   = 4;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] mmio_addr = 16'h0;
    logic        mmio_we = 1'b0;
    logic [7:0]  mmio_wdata = 8'h0;
    logic        mmio_re = 1'b0;
    logic [31:0] mmio_rdata;
    logic        uart_tx;
    logic        uart_rx = 1'b1;
    logic        rx_avail;
    logic        tx_full;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        we;
        logic        re;
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic        chk;
        logic [31:0] exp;
    } vec_t;

    localparam int NV = 13;
    vec_t vecs[NV];
    logic [39:0] cap[17];

    mmio_uart_console #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .mmio_addr(mmio_addr), .mmio_we(mmio_we),
        .mmio_wdata(mmio_wdata), .mmio_re(mmio_re), .mmio_rdata(mmio_rdata),
        .uart_tx(uart_tx), .uart_rx(uart_rx), .rx_avail(rx_avail), .tx_full(tx_full)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic mmio_write(input logic [15:0] a, input logic [7:0] d);
        mmio_addr = a; mmio_wdata = d; mmio_we = 1'b1;
        @(negedge clk);
        mmio_we = 1'b0;
    endtask

    task automatic mmio_read(input logic [15:0] a, output logic [31:0] d);
        mmio_addr = a; mmio_re = 1'b1;
        @(negedge clk);
        mmio_re = 1'b0;
        d = mmio_rdata;
    endtask

    task automatic tx_burst(input int n, input logic [7:0] base);
        mmio_addr = 16'h0020; mmio_we = 1'b1;
        for (int i = 0; i < n; i++) begin
            mmio_wdata = base + 8'(i);
            @(negedge clk);
        end
        mmio_we = 1'b0;
    endtask

    task automatic host_send(input logic [7:0] b, input logic stop);
        logic [9:0] fr;
        fr = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            uart_rx = fr[i];
            repeat (CPB) @(negedge clk);
        end
        uart_rx = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    function automatic logic [39:0] frame_bits(input logic [7:0] b);
        logic [9:0]  f;
        logic [39:0] r;
        f = {1'b1, b, 1'b0};
        for (int i = 0; i < 40; i++) r[i] = f[i / 4];
        return r;
    endfunction

    initial begin
        logic [31:0] d;
        logic [3:0]  s4;
        logic [9:0]  fr;
        int          zeros;

        repeat (3) @(negedge clk);
        check("rst_uart_tx", uart_tx, 1);
        check("rst_rdata", mmio_rdata, 0);
        check("rst_rx_avail", rx_avail, 0);
        check("rst_tx_full", tx_full, 0);
        reset = 1'b0;
        @(negedge clk);

        // register map table: {we, re, addr, wdata, chk, expected rdata}
        vecs[0]  = '{1'b0, 1'b1, 16'h0024, 8'h00, 1'b1, 32'h04};
        vecs[1]  = '{1'b0, 1'b1, 16'h0028, 8'h00, 1'b1, 32'h00};
        vecs[2]  = '{1'b0, 1'b1, 16'h0000, 8'h00, 1'b1, 32'h00};
        vecs[3]  = '{1'b0, 1'b1, 16'h0024, 8'h00, 1'b1, 32'h04};
        vecs[4]  = '{1'b1, 1'b0, 16'h0030, 8'hFF, 1'b0, 32'h00};
        vecs[5]  = '{1'b0, 1'b1, 16'h0024, 8'h00, 1'b1, 32'h04};
        vecs[6]  = '{1'b1, 1'b0, 16'h0024, 8'h30, 1'b0, 32'h00};
        vecs[7]  = '{1'b0, 1'b1, 16'h0024, 8'h00, 1'b1, 32'h04};
        vecs[8]  = '{1'b1, 1'b1, 16'h0024, 8'h00, 1'b1, 32'h00};
        vecs[9]  = '{1'b0, 1'b1, 16'h0010, 8'h00, 1'b1, 32'h00};
        vecs[10] = '{1'b0, 1'b1, 16'h002C, 8'h00, 1'b1, 32'h00};
        vecs[11] = '{1'b0, 1'b1, 16'h0020, 8'h00, 1'b1, 32'h00};
        vecs[12] = '{1'b0, 1'b1, 16'h0024, 8'h00, 1'b1, 32'h04};
        for (int i = 0; i < NV; i++) begin
            mmio_addr = vecs[i].addr; mmio_wdata = vecs[i].wdata;
            mmio_we = vecs[i].we; mmio_re = vecs[i].re;
            @(negedge clk);
            mmio_we = 1'b0; mmio_re = 1'b0;
            if (vecs[i].chk) check($sformatf("vec%0d", i), mmio_rdata, vecs[i].exp);
        end
        repeat (2) @(negedge clk);

        // TX 0xA5: first low at edge N+2, 4 cycles per bit
        mmio_write(16'h0020, 8'hA5);
        check("a5_line_n", uart_tx, 1);
        @(negedge clk);
        check("a5_line_n1", uart_tx, 1);
        @(negedge clk);
        fr = {1'b1, 8'hA5, 1'b0};
        for (int b = 0; b < 10; b++) begin
            for (int c = 0; c < 4; c++) begin
                s4[c] = uart_tx;
                @(negedge clk);
            end
            check($sformatf("a5_bit%0d", b), s4, {4{fr[b]}});
        end
        check("a5_idle_after", uart_tx, 1);
        repeat (4) @(negedge clk);

        // RX single byte 0x3C
        host_send(8'h3C, 1'b1);
        check("rx3c_avail", rx_avail, 1);
        mmio_read(16'h0024, d);
        check("rx3c_status", d, 32'h05);
        mmio_read(16'h0028, d);
        check("rx3c_data", d, 32'h3C);
        check("rx3c_avail_drop", rx_avail, 0);

        // RX overrun: 17 bytes, first 16 kept
        for (int i = 0; i < 17; i++) host_send(8'h40 + 8'(i), 1'b1);
        mmio_read(16'h0024, d);
        check("ovr_status", d, 32'h15);
        mmio_write(16'h0024, 8'h10);
        mmio_read(16'h0024, d);
        check("ovr_cleared", d, 32'h05);
        for (int i = 0; i < 16; i++) begin
            mmio_read(16'h0028, d);
            check($sformatf("ovr_data%0d", i), d, 32'h40 + i);
        end
        mmio_read(16'h0024, d);
        check("ovr_drained", d, 32'h04);

        // TX burst of 20 back-to-back stores, frames with no idle gap
        fork
            begin
                tx_burst(20, 8'h10);
                check("burst_tx_full", tx_full, 1);
                mmio_read(16'h0024, d);
                check("burst_status", d, 32'h2A);
            end
            begin
                repeat (3) @(negedge clk);
                for (int k = 0; k < 17; k++) begin
                    for (int j = 0; j < 40; j++) begin
                        cap[k][j] = uart_tx;
                        @(negedge clk);
                    end
                end
            end
        join
        for (int k = 0; k < 17; k++)
            check($sformatf("burst_frame%0d", k), cap[k], frame_bits(8'h10 + 8'(k)));
        repeat (4) @(negedge clk);
        mmio_read(16'h0024, d);
        check("burst_done_status", d, 32'h24);
        mmio_write(16'h0024, 8'h20);
        mmio_read(16'h0024, d);
        check("burst_ovf_cleared", d, 32'h04);

        // 1-cycle glitch, then a frame with a 0 stop bit
        uart_rx = 1'b0;
        @(negedge clk);
        uart_rx = 1'b1;
        repeat (12) @(negedge clk);
        check("glitch_no_push", rx_avail, 0);
        host_send(8'h99, 1'b0);
        repeat (8) @(negedge clk);
        check("ferr_no_push", rx_avail, 0);
        mmio_read(16'h0024, d);
        check("ferr_status", d, 32'h04);
        host_send(8'h81, 1'b1);
        check("ferr_recover_avail", rx_avail, 1);
        mmio_read(16'h0028, d);
        check("ferr_recover_data", d, 32'h81);

        // reset in the middle of a frame with data in both FIFOs and tx_ovf set
        host_send(8'h11, 1'b1);
        tx_burst(18, 8'h00);
        mmio_read(16'h0024, d);
        check("prerst_status", d, 32'h2B);
        repeat (4) @(negedge clk);
        check("prerst_line_low", uart_tx, 0);
        #2;
        reset = 1'b1;
        #1;
        check("rst_mid_uart_tx", uart_tx, 1);
        check("rst_mid_rdata", mmio_rdata, 0);
        check("rst_mid_rx_avail", rx_avail, 0);
        check("rst_mid_tx_full", tx_full, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        mmio_read(16'h0024, d);
        check("postrst_status", d, 32'h04);
        zeros = 0;
        for (int i = 0; i < 20; i++) begin
            if (uart_tx !== 1'b1) zeros++;
            @(negedge clk);
        end
        check("postrst_line_idle", zeros, 0);

`ifdef UART_LOOPBACK_EN
        mmio_write(16'h002C, 8'h01);
        mmio_read(16'h002C, d);
        check("lb_ctrl", d, 32'h01);
        mmio_write(16'h0020, 8'h5A);
        zeros = 0;
        for (int i = 0; i < 70; i++) begin
            if (uart_tx !== 1'b1) zeros++;
            @(negedge clk);
        end
        check("lb_line_held", zeros, 0);
        check("lb_avail", rx_avail, 1);
        mmio_read(16'h0028, d);
        check("lb_data", d, 32'h5A);
        mmio_write(16'h002C, 8'h00);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
